seg8_scan_ctrl: RTL and testbench
=================================

# seg8_scan_ctrl

Scan controller and source arbiter for the 8-digit multiplexed 7-segment display on the MCS-51 board. It accepts 32-bit display words from two requesters (CPU port, debug port) and latches a new word only at frame boundaries, so the display never tears. It sequences the eight digit strobes with a programmable slot length, dead-time blanking and 4-bit PWM brightness. It drives the digit low-side FETs directly and feeds the nibble and output enable of `decode_8seg`.

## Interface
- `PRESCALE`, default 1000: clocks per digit slot; must be ≥ `DEAD`+1.
- `DEAD`, default 8: blanking clocks at the start of every slot; must be ≥ 1.
- `CLK` in 1: single clock; everything is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `en` in 1: scan enable; low means display dark and counters cleared.
- `bright` in 4: PWM duty in sixteenths; 0 is dark, 15 is 15/16.
- `a_valid` in 1, `a_data` in 32, `a_ready` out 1: CPU requester, low priority.
- `b_valid` in 1, `b_data` in 32, `b_ready` out 1: debug requester, high priority.
- `LS_NFET` out 8: one-hot digit strobe; bit i selects digit i.
- `tetrade` out 4: nibble of the current digit, to the decoder.
- `dec_oe` out 1: decoder output enable; high only while a segment may light.
- `frame_done` out 1: one-cycle pulse at the end of slot 7.

## Operation
- **Handshake.** Transfer occurs on a cycle with valid && ready.
  - `b_ready` = !pend_full.
  - `a_ready` = !pend_full && !b_valid.
  - Both are combinational and both are 0 while `RST` is high.
- **Pending buffer.** One 32-bit entry.
  - An accepted word sets pend_full.
  - If a and b are valid in the same cycle, b is accepted and a stalls.
- **Frame boundary.** This is the cycle with slot_cnt=0 and digit=0 in BLANK.
  - If pend_full: shown ← pending and pend_full clears. Ready stays low that cycle because pend_full is still set.
  - If pending is empty: shown is held.
- **States.** IDLE, BLANK, ON.
  - IDLE → BLANK at slot_cnt=0, digit=0 when `en` is sampled 1.
  - BLANK → ON when slot_cnt reaches `DEAD`.
  - ON → BLANK at slot_cnt=`PRESCALE`-1. On that edge slot_cnt wraps to 0 and digit increments modulo 8 (7 wraps to 0).
  - Any state → IDLE in the cycle after `en` is sampled 0. slot_cnt and digit clear.
- **PWM in ON.** With p = (slot_cnt − `DEAD`) mod 16, the digit lights when p < `bright`.
  - Lit: `LS_NFET`=1<<digit, `dec_oe`=1.
  - Otherwise: `LS_NFET`=0, `dec_oe`=0.
- **Dark outputs.** In BLANK and IDLE: `LS_NFET`=0 and `dec_oe`=0.
- **`tetrade`.** Always shown[4·digit+3 : 4·digit]. Digit 4 uses bits 19:16 in natural order, least significant bit first.
- **`frame_done`.** Pulses on the ON→BLANK transition with digit=7.
- **`en` low.** The handshake keeps working; only the frame-boundary transfer is suspended.

## Timing
- **Reset values.** All outputs are registered (except the readies) and reset to:
  - `LS_NFET`=0, `tetrade`=0, `dec_oe`=0, `frame_done`=0.
  - shown=0, pend_full=0, state IDLE, slot_cnt=0, digit=0.
- **Output alignment.** Registered outputs reflect the same-cycle slot_cnt/state, with no extra pipeline stage.
- **Startup from `en`.** Let E0 be the edge that samples `en`=1. E0 starts BLANK and performs the boundary transfer. The first strobe appears after edge E0+`DEAD`, provided `bright`>0.
- **Slot and frame length.** One slot is exactly `PRESCALE` clocks; one frame is 8·`PRESCALE`.
- **Write latency.** From a word accepted to its display: at most 8·`PRESCALE`+1 clocks.
- **`bright` changes.** Sampled every cycle; there is no glitch protection beyond the dead time.
- **Reset mid-frame.** `RST` is honoured in any cycle. Outputs go dark on the next edge and a pending word is discarded.

## Structure
- **Package `seg8_pkg`:**
  - the state enum;
  - `SEG8_DIGITS`=8 and `SEG8_PWM_BITS`=4;
  - a one-hot strobe function.
- **Sub-module `seg8_src_arb`:** the two-port priority handshake plus the pending buffer. It exposes pend_full/pend_data and a take strobe to the scan FSM.
- **`decode_8seg`:** instantiated by the parent, not inside this block.

## Test plan
All scenarios use `PRESCALE`=20, `DEAD`=4.
- **Reset state.** Hold `RST` 3 cycles with `en`=1 → all outputs 0 and `a_ready`=`b_ready`=0. Release → `LS_NFET`=0x01 exactly 5 edges later with `bright`=15.
- **Full scan.** Write 0x89ABCDEF via a, `bright`=15 → each digit i is lit for 15 of the 16 ON clocks in the first pass. `tetrade` = F,E,D,C,B,A,9,8. `frame_done` pulses once every 160 cycles.
- **Arbitration.** a and b valid simultaneously → b accepted, `a_ready`=0. a is accepted only after the next frame boundary empties the buffer.
- **Tear-free update.** Write a new word mid-frame → `tetrade` keeps the old word until digit 0 of the next frame.
- **Brightness.** `bright`=0 → `dec_oe` never high. `bright`=4 → 4 lit clocks per ON window, 16 ON clocks per slot.
- **Disable.** Drop `en` mid-ON at digit 5 → next edge `LS_NFET`=0. Re-enable → restarts at digit 0 with BLANK.

Source files
------------

// File: rtl/seg8_pkg.sv
// Shared types and constants for the 8-digit multiplexed 7-segment scan controller.
package seg8_pkg;

    localparam int SEG8_DIGITS     = 8;
    localparam int SEG8_PWM_BITS   = 4;
    localparam int SEG8_DIGIT_BITS = $clog2(SEG8_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ON
    } seg8_state_t;

    function automatic logic [SEG8_DIGITS-1:0] seg8_onehot(input logic [SEG8_DIGIT_BITS-1:0] idx);
        logic [SEG8_DIGITS-1:0] strobe;
        strobe      = '0;
        strobe[idx] = 1'b1;
        return strobe;
    endfunction

endpackage

// File: rtl/seg8_src_arb.sv
// Two-port display-word arbiter with a single pending entry; debug port b wins over CPU port a.
module seg8_src_arb
    import seg8_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        a_valid,
    input  logic [31:0] a_data,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [31:0] b_data,
    output logic        b_ready,
    input  logic        take,
    output logic        pend_full,
    output logic [31:0] pend_data
);

    assign b_ready = !RST && !pend_full;
    assign a_ready = !RST && !pend_full && !b_valid;

    // take only fires while full and accepts only while empty, so they never collide
    always_ff @(posedge CLK) begin
        if (RST) begin
            pend_full <= 1'b0;
            pend_data <= '0;
        end else if (take) begin
            pend_full <= 1'b0;
        end else if (b_valid && b_ready) begin
            pend_full <= 1'b1;
            pend_data <= b_data;
        end else if (a_valid && a_ready) begin
            pend_full <= 1'b1;
            pend_data <= a_data;
        end
    end

endmodule

// File: rtl/seg8_scan_ctrl.sv
// Digit scan sequencer: frame-aligned word update, dead-time blanking and PWM brightness
// for the 8-digit display; outputs are registered from the next-state values.
module seg8_scan_ctrl
    import seg8_pkg::*;
#(
    parameter int PRESCALE = 1000,
    parameter int DEAD     = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     en,
    input  logic [SEG8_PWM_BITS-1:0] bright,
    input  logic                     a_valid,
    input  logic [31:0]              a_data,
    output logic                     a_ready,
    input  logic                     b_valid,
    input  logic [31:0]              b_data,
    output logic                     b_ready,
    output logic [SEG8_DIGITS-1:0]   LS_NFET,
    output logic [3:0]               tetrade,
    output logic                     dec_oe,
    output logic                     frame_done
);

    localparam int CW = $clog2(PRESCALE);
    localparam int DW = SEG8_DIGIT_BITS;
    localparam logic [CW-1:0] DEAD_C = CW'(DEAD);
    localparam logic [CW-1:0] LAST_C = CW'(PRESCALE - 1);

    seg8_state_t              state, state_nx;
    logic [CW-1:0]            slot_cnt, slot_nx;
    logic [DW-1:0]            digit, digit_nx;
    logic [31:0]              shown, shown_nx;
    logic                     boundary, take, frame_end, lit_nx;
    logic                     pend_full;
    logic [31:0]              pend_data;
    logic [SEG8_PWM_BITS-1:0] pwm_pos;

    seg8_src_arb u_arb (
        .CLK       (CLK),
        .RST       (RST),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .take      (take),
        .pend_full (pend_full),
        .pend_data (pend_data)
    );

    // Leaving IDLE counts as the first frame boundary so a queued word shows immediately
    assign boundary = en && ((state == ST_IDLE) ||
                             (state == ST_BLANK && slot_cnt == '0 && digit == '0));
    assign take     = boundary && pend_full;
    assign shown_nx = take ? pend_data : shown;

    always_comb begin
        state_nx  = state;
        slot_nx   = slot_cnt;
        digit_nx  = digit;
        frame_end = 1'b0;
        if (!en) begin
            state_nx = ST_IDLE;
            slot_nx  = '0;
            digit_nx = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nx = ST_BLANK;
                    slot_nx  = '0;
                    digit_nx = '0;
                end
                ST_BLANK: begin
                    slot_nx = slot_cnt + CW'(1);
                    if (slot_nx == DEAD_C) state_nx = ST_ON;
                end
                ST_ON: begin
                    if (slot_cnt == LAST_C) begin
                        state_nx  = ST_BLANK;
                        slot_nx   = '0;
                        digit_nx  = digit + DW'(1);
                        frame_end = (digit == DW'(SEG8_DIGITS - 1));
                    end else begin
                        slot_nx = slot_cnt + CW'(1);
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    slot_nx  = '0;
                    digit_nx = '0;
                end
            endcase
        end
    end

    assign pwm_pos = SEG8_PWM_BITS'(slot_nx - DEAD_C);
    assign lit_nx  = (state_nx == ST_ON) && (pwm_pos < bright);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            slot_cnt   <= '0;
            digit      <= '0;
            shown      <= '0;
            LS_NFET    <= '0;
            tetrade    <= '0;
            dec_oe     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            slot_cnt   <= slot_nx;
            digit      <= digit_nx;
            shown      <= shown_nx;
            LS_NFET    <= lit_nx ? seg8_onehot(digit_nx) : '0;
            tetrade    <= shown_nx[{digit_nx, 2'b00} +: 4];
            dec_oe     <= lit_nx;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_seg8_scan_ctrl.sv
// Self-checking bench for seg8_scan_ctrl: time-indexed reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_seg8_scan_ctrl;

    localparam int P     = 20;
    localparam int DEAD  = 4;
    localparam int FRAME = 8 * P;

    logic        CLK = 1'b0;
    logic        RST;
    logic        en;
    logic [3:0]  bright;
    logic        a_valid, b_valid;
    logic [31:0] a_data, b_data;
    logic        a_ready, b_ready;
    logic [7:0]  LS_NFET;
    logic [3:0]  tetrade;
    logic        dec_oe, frame_done;

    int tests_run    = 0;
    int tests_failed = 0;
    bit chk_en       = 1'b0;

    bit          m_run, m_pfull, m_oe, m_fd;
    int          m_t;
    logic [31:0] m_pdata, m_shown;
    logic [7:0]  m_ls;
    logic [3:0]  m_tet;

    seg8_scan_ctrl #(.PRESCALE(P), .DEAD(DEAD)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .en         (en),
        .bright     (bright),
        .a_valid    (a_valid),
        .a_data     (a_data),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_data     (b_data),
        .b_ready    (b_ready),
        .LS_NFET    (LS_NFET),
        .tetrade    (tetrade),
        .dec_oe     (dec_oe),
        .frame_done (frame_done)
    );

    always #5 CLK = ~CLK;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic av, input logic [31:0] ad,
                                  input logic bv, input logic [31:0] bd);
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
    endtask

    // Reference model: position in the scan is just the number of edges since enable
    always @(posedge CLK) begin : ref_model
        int          nt, slot, dig;
        bit          nrun, lit, bnd;
        logic [31:0] nshown;
        if (RST) begin
            m_run   <= 1'b0;
            m_t     <= 0;
            m_pfull <= 1'b0;
            m_pdata <= '0;
            m_shown <= '0;
            m_ls    <= '0;
            m_oe    <= 1'b0;
            m_tet   <= '0;
            m_fd    <= 1'b0;
        end else begin
            bnd    = en && (!m_run || (m_t % FRAME == 0));
            nshown = m_shown;
            if (m_pfull) begin
                if (bnd) begin
                    nshown = m_pdata;
                    m_pfull <= 1'b0;
                end
            end else if (b_valid) begin
                m_pfull <= 1'b1;
                m_pdata <= b_data;
            end else if (a_valid) begin
                m_pfull <= 1'b1;
                m_pdata <= a_data;
            end
            if (!en) begin
                nrun = 1'b0;
                nt   = 0;
            end else if (!m_run) begin
                nrun = 1'b1;
                nt   = 0;
            end else begin
                nrun = 1'b1;
                nt   = m_t + 1;
            end
            slot = nt % P;
            dig  = (nt / P) % 8;
            lit  = nrun && (slot >= DEAD) && (((slot - DEAD) % 16) < int'(bright));
            m_run   <= nrun;
            m_t     <= nt;
            m_shown <= nshown;
            m_ls    <= lit ? (8'd1 << dig) : 8'd0;
            m_oe    <= lit;
            m_tet   <= nshown[dig*4 +: 4];
            m_fd    <= nrun && m_run && (nt % FRAME == 0);
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check_output("LS_NFET", LS_NFET, m_ls);
            check_output("dec_oe", dec_oe, m_oe);
            check_output("tetrade", tetrade, m_tet);
            check_output("frame_done", frame_done, m_fd);
            check_output("b_ready", b_ready, !RST && !m_pfull);
            check_output("a_ready", a_ready, !RST && !m_pfull && !b_valid);
        end
    end

    initial begin
        logic [3:0] exp_nib [8];
        int         lit_cnt [8];
        logic [3:0] tet_at  [8];
        int         fd_k [2];
        int         fd_n, cnt, run_len, max_run;
        bit         found;

        exp_nib = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8};

        // Reset state, with both requesters asking to prove readies stay low
        RST = 1'b1; en = 1'b1; bright = 4'd15;
        apply_stimulus(1'b1, 32'h0, 1'b1, 32'h0);
        @(posedge CLK); #1 chk_en = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_output("rst_LS_NFET", LS_NFET, 8'h00);
        check_output("rst_tetrade", tetrade, 4'h0);
        check_output("rst_dec_oe", dec_oe, 1'b0);
        check_output("rst_frame_done", frame_done, 1'b0);
        check_output("rst_a_ready", a_ready, 1'b0);
        check_output("rst_b_ready", b_ready, 1'b0);
        @(posedge CLK); #1 RST = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (4) @(posedge CLK);
        @(negedge CLK) check_output("startup_dark", LS_NFET, 8'h00);
        @(posedge CLK);
        @(negedge CLK) check_output("startup_first", LS_NFET, 8'h01);

        // Full scan of one word written through the CPU port
        @(posedge CLK); #1 RST = 1'b1; en = 1'b0;
        @(posedge CLK); #1 RST = 1'b0;
        apply_stimulus(1'b1, 32'h89ABCDEF, 1'b0, 32'h0);
        @(posedge CLK); #1 a_valid = 1'b0; en = 1'b1;
        @(posedge CLK);
        for (int i = 0; i < 8; i++) begin
            lit_cnt[i] = 0;
            tet_at[i]  = 4'h0;
        end
        fd_n = 0; fd_k[0] = -1; fd_k[1] = -1;
        for (int k = 0; k < 330; k++) begin
            @(negedge CLK);
            for (int i = 0; i < 8; i++) begin
                if (k < FRAME && LS_NFET == (8'd1 << i)) begin
                    if (lit_cnt[i] == 0) tet_at[i] = tetrade;
                    lit_cnt[i]++;
                end
            end
            if (frame_done) begin
                if (fd_n < 2) fd_k[fd_n] = k;
                fd_n++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("scan_lit_cnt_d%0d", i), lit_cnt[i], 15);
            check_output($sformatf("scan_tetrade_d%0d", i), tet_at[i], exp_nib[i]);
        end
        check_output("scan_fd_count", fd_n, 2);
        check_output("scan_fd_first", fd_k[0], FRAME);
        check_output("scan_fd_period", fd_k[1] - fd_k[0], FRAME);

        // Arbitration and tear-free update
        @(posedge CLK); #1 en = 1'b0;
        apply_stimulus(1'b1, 32'h22222222, 1'b1, 32'h11111111);
        @(negedge CLK);
        check_output("arb_a_ready_blocked", a_ready, 1'b0);
        check_output("arb_b_ready", b_ready, 1'b1);
        @(posedge CLK);
        @(negedge CLK);
        check_output("arb_full_b_ready", b_ready, 1'b0);
        check_output("arb_full_a_ready", a_ready, 1'b0);
        @(posedge CLK); #1 b_valid = 1'b0; en = 1'b1;
        @(posedge CLK);
        for (int k = 0; k <= 170; k++) begin
            @(negedge CLK);
            if (k == 0) begin
                check_output("arb_a_ready_after_take", a_ready, 1'b1);
                @(posedge CLK); #1 a_valid = 1'b0;
            end
            if (k == 24) begin
                check_output("tear_d1_strobe", LS_NFET, 8'h02);
                check_output("tear_d1_old", tetrade, 4'h1);
            end
            if (k == 150) check_output("tear_d7_old", tetrade, 4'h1);
            if (k == 164) begin
                check_output("tear_d0_strobe", LS_NFET, 8'h01);
                check_output("tear_d0_new", tetrade, 4'h2);
            end
        end

        // Brightness
        @(posedge CLK); #1 bright = 4'd0;
        @(posedge CLK);
        cnt = 0;
        repeat (FRAME) begin
            @(negedge CLK);
            if (dec_oe) cnt++;
        end
        check_output("bright0_oe_cnt", cnt, 0);
        @(posedge CLK); #1 bright = 4'd4;
        @(posedge CLK);
        cnt = 0; run_len = 0; max_run = 0;
        repeat (FRAME) begin
            @(negedge CLK);
            if (dec_oe) begin
                cnt++;
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
        end
        check_output("bright4_oe_cnt", cnt, 32);
        check_output("bright4_max_run", max_run, 4);

        // Disable mid-ON at digit 5, then restart from digit 0
        @(posedge CLK); #1 bright = 4'd15;
        found = 1'b0;
        for (int k = 0; k < 400 && !found; k++) begin
            @(negedge CLK);
            if (LS_NFET == 8'h20) found = 1'b1;
        end
        check_output("dis_reach_digit5", found, 1'b1);
        @(posedge CLK); #1 en = 1'b0;
        @(posedge CLK);
        @(negedge CLK) check_output("dis_dark", LS_NFET, 8'h00);
        @(posedge CLK); #1 en = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK) check_output("reen_dark", LS_NFET, 8'h00);
        @(posedge CLK);
        @(negedge CLK) check_output("reen_digit0", LS_NFET, 8'h01);

        // Randomized traffic checked by the model
        for (int c = 0; c < 4000; c++) begin
            @(posedge CLK); #1;
            RST = ($urandom_range(999) == 0);
            if ($urandom_range(299) == 0) en = ~en;
            else if (!en && $urandom_range(9) == 0) en = 1'b1;
            if ($urandom_range(49) == 0) bright = 4'($urandom);
            apply_stimulus($urandom_range(3) == 0, $urandom, $urandom_range(7) == 0, $urandom);
        end
        @(posedge CLK); #1 RST = 1'b0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
